// File: rtl/ulight_fifo_rx_read_ctrl.sv
// ulight_fifo_rx_read_ctrl
// Read sequencer for the uLight SpaceWire RX FIFO. Pops one entry at a time into a holding
// register and presents it to the CPU through a 4-word Avalon-MM slave, together with FIFO
// status, enable and threshold-interrupt configuration.
//
// Ports:
//   clk, reset_n           system clock; synchronous active-low reset
//   address/read/write     Avalon-MM slave (word address 0..3, one-cycle strobes)
//   writedata, readdata    write data in, registered read data out
//   fifo_rd_en             FIFO pop strobe (one cycle, FETCH state only)
//   fifo_dout              FIFO output, valid the cycle after fifo_rd_en
//   fifo_empty, fifo_count FIFO status
//   irq                    registered level interrupt (occupancy >= threshold)
module ulight_fifo_rx_read_ctrl #(
   parameter int unsigned DATA_WIDTH  = 9,
   parameter int unsigned COUNT_WIDTH = 6
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [1:0]             address,
   input  logic                   read,
   input  logic                   write,
   input  logic [31:0]            writedata,
   output logic [31:0]            readdata,
   output logic                   fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   input  logic                   fifo_empty,
   input  logic [COUNT_WIDTH-1:0] fifo_count,
   output logic                   irq
);

   typedef enum logic [1:0] {StEmpty, StFetch, StWait, StFull} state_e;

   state_e                 state_q, state_d;
   logic                   enable_q, enable_d;
   logic                   irq_en_q, irq_en_d;
   logic [COUNT_WIDTH-1:0] thresh_q, thresh_d;
   logic [DATA_WIDTH-1:0]  hold_q, hold_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [31:0]            readdata_q, readdata_d;
   logic                   irq_q, irq_d;
   logic [COUNT_WIDTH:0]   level;
   logic                   data_pop;

   // Only the threshold-sized low bits of writedata are ever stored.
   logic unused_wdata;
   assign unused_wdata = ^writedata[31:COUNT_WIDTH];

   always_comb begin
      state_d      = state_q;
      enable_d     = enable_q;
      irq_en_d     = irq_en_q;
      thresh_d     = thresh_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      readdata_d   = readdata_q;

      // One extra bit so a full FIFO plus a held word cannot wrap.
      level = {1'b0, fifo_count} + {{COUNT_WIDTH{1'b0}}, hold_valid_q};
      irq_d = irq_en_q && (thresh_q != '0) && (level >= {1'b0, thresh_q});

      // The pop side effect of a DATA read exists only while a word is held.
      data_pop = read && (address == 2'd0) && (state_q == StFull);

      unique case (state_q)
         StEmpty: if (enable_q && !fifo_empty) state_d = StFetch;
         StFetch: state_d = StWait;
         StWait: begin
            hold_d       = fifo_dout;
            hold_valid_d = 1'b1;
            state_d      = StFull;
         end
         StFull: begin
            if (data_pop) begin
               hold_valid_d = 1'b0;
               state_d      = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase

      // A read takes priority; a write in the same cycle is dropped.
      if (read) begin
         readdata_d = '0;
         unique case (address)
            2'd0: begin
               // Stale hold contents are masked so a non-valid read returns zero.
               if (hold_valid_q) begin
                  readdata_d[31]             = 1'b1;
                  readdata_d[DATA_WIDTH-1:0] = hold_q;
               end
            end
            2'd1: begin
               readdata_d[COUNT_WIDTH-1:0] = fifo_count;
               readdata_d[16]              = fifo_empty;
               readdata_d[17]              = hold_valid_q;
               readdata_d[18]              = irq_q;
            end
            2'd2: begin
               readdata_d[0] = enable_q;
               readdata_d[1] = irq_en_q;
            end
            2'd3: readdata_d[COUNT_WIDTH-1:0] = thresh_q;
            default: readdata_d = '0;
         endcase
      end else if (write) begin
         case (address)
            2'd2: begin
               enable_d = writedata[0];
               irq_en_d = writedata[1];
            end
            2'd3: thresh_d = writedata[COUNT_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StEmpty;
         enable_q     <= 1'b0;
         irq_en_q     <= 1'b0;
         thresh_q     <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         readdata_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         irq_en_q     <= irq_en_d;
         thresh_q     <= thresh_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         readdata_q   <= readdata_d;
         irq_q        <= irq_d;
      end
   end

   assign fifo_rd_en = (state_q == StFetch);
   assign readdata   = readdata_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_ulight_fifo_rx_read_ctrl.sv
// Bench for ulight_fifo_rx_read_ctrl: directed cycle-level checks followed by randomized bus and
// FIFO traffic checked against a transaction-level model (a word is held whenever enabled and
// the FIFO has data; DATA reads consume it).
module tb_ulight_fifo_rx_read_ctrl;
   localparam int unsigned DW = 9;
   localparam int unsigned CW = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          irq;

   ulight_fifo_rx_read_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Bench-side RX FIFO: ring buffer, pushed from the stimulus, popped by the DUT.
   logic [DW-1:0] mem [256];
   logic [7:0]    push_cnt = '0;
   logic [7:0]    pop_cnt = '0;
   int            rd_pulses = 0;

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= mem[pop_cnt];
         pop_cnt   <= pop_cnt + 8'd1;
         rd_pulses <= rd_pulses + 1;
      end
   end

   assign fifo_count = CW'(push_cnt - pop_cnt);
   assign fifo_empty = (push_cnt == pop_cnt);

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model state.
   logic [DW-1:0] mq [$];
   logic          m_en, m_ie, m_hv;
   logic [CW-1:0] m_th;
   logic [DW-1:0] m_hold;
   int            exp_pulses;

   task automatic push(input logic [DW-1:0] w);
      mem[push_cnt] = w;
      push_cnt      = push_cnt + 8'd1;
      mq.push_back(w);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the next negedge with readdata valid.
   task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd);
      address   = a;
      read      = rd;
      write     = wr;
      writedata = wd;
      @(negedge clk);
      read  = 1'b0;
      write = 1'b0;
   endtask

   function automatic logic model_irq();
      return m_ie && (m_th != '0) && ((mq.size() + int'(m_hv)) >= int'(m_th));
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: if (m_hv) r = 32'h8000_0000 | 32'(m_hold);
         2'd1: r = 32'(mq.size()) | (32'(mq.size() == 0) << 16) | (32'(m_hv) << 17)
                   | (32'(model_irq()) << 18);
         2'd2: r = {30'b0, m_ie, m_en};
         default: r = 32'(m_th);
      endcase
      return r;
   endfunction

   // Once traffic quiesces, an enabled controller always holds the next FIFO word.
   task automatic model_settle();
      if (m_en && !m_hv && mq.size() > 0) begin
         m_hold = mq.pop_front();
         m_hv   = 1'b1;
         exp_pulses++;
      end
   endtask

   logic [31:0] wd;
   logic [1:0]  a;
   int          op;
   logic [7:0]  idx;

   initial begin
      @(negedge clk);
      reset_n = 1'b0;
      cycles(3);
      check_eq("rst_readdata", readdata, 32'h0);
      check_eq("rst_irq", 32'(irq), 32'h0);
      check_eq("rst_rd_en", 32'(fifo_rd_en), 32'h0);
      reset_n = 1'b1;

      // Disabled: no pops regardless of FIFO contents.
      push(9'h0A5);
      push(9'h13C);
      push(9'h077);
      cycles(10);
      check_eq("dis_no_pop", 32'(rd_pulses), 32'd0);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("dis_status", readdata, 32'h0000_0003);
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("dis_data", readdata, 32'h0);

      // Enable: pop on e+1, hold_valid visible to a read sampled at e+4.
      bus(1'b0, 1'b1, 2'd2, 32'h1);
      check_eq("en_rd_e0", 32'(fifo_rd_en), 32'h0);
      cycles(1);
      check_eq("en_rd_e1", 32'(fifo_rd_en), 32'h1);
      cycles(1);
      check_eq("en_rd_e2", 32'(fifo_rd_en), 32'h0);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("en_status_e3", readdata, 32'h0000_0002);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("en_status_e4", readdata, 32'h0002_0002);
      cycles(5);
      check_eq("en_one_pulse", 32'(rd_pulses), 32'd1);

      // DATA read and refill schedule.
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("data0", readdata, 32'h8000_00A5);
      check_eq("refill_n1_empty", 32'(fifo_rd_en), 32'h0);
      cycles(1);
      check_eq("refill_n2_fetch", 32'(fifo_rd_en), 32'h1);
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("refill_read_in_fetch", readdata, 32'h0);
      check_eq("refill_n3_wait", 32'(fifo_rd_en), 32'h0);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("refill_status_wait", readdata, 32'h0000_0001);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("refill_status_full", readdata, 32'h0002_0001);
      cycles(3);
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("data1", readdata, 32'h8000_013C);
      cycles(6);
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("data2", readdata, 32'h8000_0077);
      cycles(6);
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("data_empty", readdata, 32'h0);
      cycles(4);
      check_eq("data_pulses", 32'(rd_pulses), 32'd3);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("status_empty", readdata, 32'h0001_0000);

      // Threshold interrupt: level = 3 in FIFO + 1 held = 4.
      push(9'h1F0);
      push(9'h0FF);
      push(9'h100);
      push(9'h055);
      cycles(6);
      bus(1'b0, 1'b1, 2'd2, 32'h3);
      bus(1'b0, 1'b1, 2'd3, 32'h4);
      cycles(2);
      check_eq("irq_at_thresh", 32'(irq), 32'h1);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("irq_status", readdata, 32'h0006_0003);
      bus(1'b0, 1'b1, 2'd3, 32'h5);
      cycles(2);
      check_eq("irq_below_thresh", 32'(irq), 32'h0);
      bus(1'b0, 1'b1, 2'd3, 32'h0);
      cycles(2);
      check_eq("irq_thresh_zero", 32'(irq), 32'h0);
      bus(1'b0, 1'b1, 2'd3, 32'h4);
      cycles(2);
      check_eq("irq_rearm", 32'(irq), 32'h1);
      bus(1'b1, 1'b0, 2'd0, 32'h0);
      check_eq("irq_data", readdata, 32'h8000_01F0);
      check_eq("irq_lag", 32'(irq), 32'h1);
      cycles(1);
      check_eq("irq_drop", 32'(irq), 32'h0);

      // Reset while in WAIT: the popped word is lost.
      cycles(1);
      reset_n = 1'b0;
      cycles(1);
      reset_n = 1'b1;
      check_eq("wrst_irq", 32'(irq), 32'h0);
      check_eq("wrst_readdata", readdata, 32'h0);
      check_eq("wrst_rd_en", 32'(fifo_rd_en), 32'h0);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("wrst_status", readdata, 32'h0000_0002);
      bus(1'b1, 1'b0, 2'd2, 32'h0);
      check_eq("wrst_ctrl", readdata, 32'h0);
      bus(1'b1, 1'b0, 2'd3, 32'h0);
      check_eq("wrst_thresh", readdata, 32'h1);
      cycles(5);
      check_eq("wrst_pulses", 32'(rd_pulses), 32'd5);

      // Read wins over a simultaneous write; writes to 0/1 are ignored.
      bus(1'b0, 1'b1, 2'd3, 32'h5);
      bus(1'b1, 1'b1, 2'd3, 32'h9);
      check_eq("rw_old_thresh", readdata, 32'h5);
      bus(1'b1, 1'b0, 2'd3, 32'h0);
      check_eq("rw_thresh_kept", readdata, 32'h5);
      bus(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF);
      bus(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF);
      bus(1'b1, 1'b0, 2'd2, 32'h0);
      check_eq("ro_ctrl", readdata, 32'h0);
      bus(1'b1, 1'b0, 2'd3, 32'h0);
      check_eq("ro_thresh", readdata, 32'h5);
      bus(1'b1, 1'b0, 2'd1, 32'h0);
      check_eq("ro_status", readdata, 32'h0000_0002);
      cycles(3);
      check_eq("ro_pulses", 32'(rd_pulses), 32'd5);

      // Randomized traffic against the transaction model.
      m_en = 1'b0;
      m_ie = 1'b0;
      m_hv = 1'b0;
      m_th = 6'd5;
      m_hold = '0;
      exp_pulses = 5;
      mq.delete();
      for (idx = pop_cnt; idx != push_cnt; idx = idx + 8'd1) mq.push_back(mem[idx]);

      for (int i = 0; i < 200; i++) begin
         op = int'($urandom_range(0, 9));
         a  = 2'($urandom_range(0, 3));
         wd = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
         if (op <= 2) begin
            if (mq.size() < 60) push(DW'($urandom_range(0, 511)));
            cycles(1);
         end else if (op <= 5 || op == 8) begin
            bus(1'b1, op == 8, a, wd);
            check_eq($sformatf("rnd_read%0d_a%0d", i, a), readdata, model_read(a));
            if (a == 2'd0) m_hv = 1'b0;
         end else if (op <= 7) begin
            bus(1'b0, 1'b1, a, wd);
            if (a == 2'd2) begin
               m_en = wd[0];
               m_ie = wd[1];
            end else if (a == 2'd3) begin
               m_th = wd[CW-1:0];
            end
         end else begin
            cycles(1);
         end
         cycles(6);
         model_settle();
         check_eq($sformatf("rnd_irq%0d", i), 32'(irq), 32'(model_irq()));
         check_eq($sformatf("rnd_pulses%0d", i), 32'(rd_pulses), 32'(exp_pulses));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ulight_fifo_rx_read_ctrl.md
# ulight_fifo_rx_read_ctrl

Read sequencer for the uLight SpaceWire RX FIFO. It pops one 9-bit entry (8 data bits plus an end-of-packet flag bit) at a time into a holding register and exposes it to the CPU through a 4-word Avalon-MM slave. It also exposes FIFO status, enable and threshold-interrupt configuration. It sits between the RX FIFO read port and the CPU bus, and replaces direct polling of the raw FIFO data/flag port.

## Interface
Parameters:
- DATA_WIDTH, 9: FIFO entry width; bit 8 is the EOP/EEP flag, bits 7:0 are data.
- COUNT_WIDTH, 6: width of the FIFO occupancy count.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe, one cycle per access.
- write  in  1  Avalon write strobe, one cycle per access.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data.
- fifo_rd_en  out  1  FIFO pop strobe.
- fifo_dout  in  DATA_WIDTH  FIFO output; valid exactly 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  COUNT_WIDTH  FIFO occupancy.
- irq  out  1  registered level interrupt.

## Operation
- Registers:
  - ctrl.enable, reset 0.
  - ctrl.irq_en, reset 0.
  - thresh[COUNT_WIDTH-1:0], reset 1.
  - hold[DATA_WIDTH-1:0], reset 0.
  - hold_valid, reset 0.
- FSM states: EMPTY, FETCH, WAIT, FULL. Reset state is EMPTY.
  - EMPTY → FETCH when enable=1 and fifo_empty=0. Otherwise stay.
  - FETCH: fifo_rd_en=1 for exactly this one cycle. Always → WAIT.
  - WAIT: hold ← fifo_dout, hold_valid ← 1. → FULL.
  - FULL: a read of address 0 sets hold_valid ← 0 and moves to EMPTY. Otherwise stay.
  - fifo_rd_en = (state==FETCH) and is never asserted in any other state.
- Register map (read):
  - Address 0 (DATA): {hold_valid, 22'b0, hold[8:0]}. The pop side effect occurs only in FULL. A read in any other state returns bit31=0 and changes no state.
  - Address 1 (STATUS): [COUNT_WIDTH-1:0]=fifo_count, [16]=fifo_empty, [17]=hold_valid, [18]=irq. All other bits 0.
  - Address 2 (CTRL): [0]=enable, [1]=irq_en.
  - Address 3 (THRESH): thresh, zero-extended.
- Register map (write):
  - Address 2 writes bits [1:0].
  - Address 3 writes thresh.
  - Writes to addresses 0 and 1 are ignored.
- Clearing enable blocks only the EMPTY→FETCH transition. FETCH and WAIT always complete, and the hold register stays valid until read.
- Level and interrupt:
  - level = fifo_count + hold_valid, computed COUNT_WIDTH+1 bits wide with no wrap.
  - irq ← irq_en & (thresh≠0) & (level ≥ thresh).
- Simultaneous read and write: the read is performed and the write is dropped.

## Timing
- readdata is registered. It is valid the cycle after read is sampled, and holds its value until the next read.
- Reset values: readdata=0, irq=0, fifo_rd_en=0.
- Refill after a DATA read, with FIFO non-empty and enable=1:
  - cycle n+1: EMPTY;
  - cycle n+2: FETCH (rd_en);
  - cycle n+3: WAIT;
  - cycle n+4: FULL.
  - Minimum DATA re-read spacing for valid data is therefore 4 cycles.
- From enable=1 with the FIFO already non-empty, hold_valid rises 3 cycles after the enable write.
- irq lags level changes by 1 cycle.
- reset_n=0 sampled in any state, including FETCH or WAIT, forces EMPTY and clears hold, hold_valid, all config registers, readdata and irq on that edge.
  - A FIFO word popped in FETCH before reset is lost; this is accepted.

## Test plan
- Reset then idle, FIFO holding 3 entries, enable=0: fifo_rd_en never asserts. STATUS reads count=3, empty=0, hold_valid=0.
- Write CTRL=1 with FIFO {0x0A5, 0x13C}:
  - exactly one fifo_rd_en pulse;
  - DATA read returns 0x800000A5;
  - refill follows on the cycle-level schedule above;
  - next DATA read returns 0x8000013C;
  - a third DATA read returns 0x00000000 and no pop occurs.
- thresh=4, irq_en=1, FIFO count 3 plus hold_valid=1: irq=1. After a DATA read the level drops to 3, and irq=0 one cycle after the level change.
- Reset_n pulsed low while in WAIT: the next cycle shows state EMPTY, hold_valid=0, CTRL reads 0, thresh reads 1, irq=0.
- Read and write both asserted at address 3 with writedata=9: readdata returns the old thresh and thresh is unchanged. Writes to addresses 0 and 1 leave all state unchanged.
